random_arbiter: RTL and testbench

Round-robin server that shares one 20-bit Fibonacci LFSR among `N_REQ` game-logic requesters, such as the obstacle spawner, coin spawner and lane picker. Every grant delivers a fresh word that no other requester has seen, and the LFSR advances `STEPS` shifts between consecutive words to decorrelate them. The block sits between the game-state logic and the spawn units and replaces the per-unit free-running generators.

---
 rtl/random_arbiter.sv | 166 ++++++++++++++++
 tb/tb_random_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/random_arbiter.sv
// ---------------------------------------------------------------------------
// random_arbiter
//
// Round-robin server for one shared 20-bit Fibonacci LFSR. Each grant hands
// exactly one requester a freshly staged word. Between words the LFSR is
// advanced STEPS times so consecutive words are decorrelated.
//
// Optional feature macro: RNG_SEED_LOAD_EN (adds seed_load / seed_in).
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   STEPS  LFSR shifts between delivered words (1..31)
//   SEED   LFSR value after reset (nonzero)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset
//   seed_load  in   1      force reseed (only with RNG_SEED_LOAD_EN)
//   seed_in    in   20     reseed value, 0 maps to 1 (only with RNG_SEED_LOAD_EN)
//   req        in   N_REQ  level requests, held until granted
//   gnt        out  N_REQ  one-hot grant, single-cycle pulse
//   rnd_valid  out  1      high in the grant cycle
//   rnd_data   out  20     delivered word, holds between grants
//   ready      out  1      word staged, grant can issue on the next edge
// ---------------------------------------------------------------------------
module random_arbiter #(
    parameter int          N_REQ = 4,
    parameter int          STEPS = 20,
    parameter logic [19:0] SEED  = 20'h00001
) (
    input  logic             clk,
    input  logic             rst,
`ifdef RNG_SEED_LOAD_EN
    input  logic             seed_load,
    input  logic [19:0]      seed_in,
`endif
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             rnd_valid,
    output logic [19:0]      rnd_data,
    output logic             ready
);

    localparam int CNT_W  = 5;
    localparam int LAST_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_REFILL = 1'b0,
        ST_READY  = 1'b1
    } state_e;

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [19:0]        lfsr_q,   lfsr_d;
    logic [LAST_W-1:0]  last_q,   last_d;
    logic [N_REQ-1:0]   gnt_q,    gnt_d;
    logic               valid_q,  valid_d;
    logic [19:0]        data_q,   data_d;

    logic               win_found;
    logic [LAST_W-1:0]  win_idx;
    logic [19:0]        lfsr_shift;

    // Taps 19 and 16 give a maximal-length 20-bit sequence.
    assign lfsr_shift = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};

    // ------------------------------------------------------------------
    // Round-robin pick: scan last+1, last+2, ... wrapping modulo N_REQ;
    // the first set request wins. last itself is visited last.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no
        // path leaves it unassigned, which would infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            logic [LAST_W-1:0] cand;
            cand = LAST_W'((int'(last_q) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        last_d  = last_q;
        gnt_d   = '0;      // grant and valid are pulses: cleared unless set
        valid_d = 1'b0;
        data_d  = data_q;  // delivered word holds between grants

        unique case (state_q)
            ST_REFILL: begin
                lfsr_d = lfsr_shift;
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                // LFSR is frozen here so an idle wait keeps the staged word.
                if (win_found) begin
                    gnt_d   = N_REQ'(1) << win_idx;
                    valid_d = 1'b1;
                    data_d  = lfsr_q;
                    last_d  = win_idx;
                    state_d = ST_REFILL;
                end
            end
            default: state_d = ST_REFILL;
        endcase

`ifdef RNG_SEED_LOAD_EN
        // A load overrides everything, including a grant that would issue
        // this cycle. Zero would lock the LFSR, so it is replaced by 1.
        if (seed_load) begin
            lfsr_d  = (seed_in == 20'h00000) ? 20'h00001 : seed_in;
            cnt_d   = '0;
            state_d = ST_REFILL;
            last_d  = LAST_W'(N_REQ - 1);
            gnt_d   = '0;
            valid_d = 1'b0;
            data_d  = data_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values; every register is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_REFILL;
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            last_q  <= LAST_W'(N_REQ - 1);  // req[0] wins the first grant
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = valid_q;
    assign rnd_data  = data_q;
    assign ready     = (state_q == ST_READY);

endmodule

// File: tb/tb_random_arbiter.sv
// ---------------------------------------------------------------------------
// tb_random_arbiter
//
// Directed bench for random_arbiter (N_REQ=4, STEPS=20, SEED=1). Inputs are
// driven on the falling edge and outputs sampled there too. Expected words
// come from hand-computed constants and a small model of the LFSR
// recurrence; grant order comes from hand-written tables.
// ---------------------------------------------------------------------------
module tb_random_arbiter;

    localparam int          N_REQ = 4;
    localparam int          STEPS = 20;
    localparam logic [19:0] SEED  = 20'h00001;
    localparam int          SPACE = STEPS + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             rnd_valid;
    logic [19:0]      rnd_data;
    logic             ready;
`ifdef RNG_SEED_LOAD_EN
    logic             seed_load;
    logic [19:0]      seed_in;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    random_arbiter #(.N_REQ(N_REQ), .STEPS(STEPS), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RNG_SEED_LOAD_EN
        .seed_load (seed_load),
        .seed_in   (seed_in),
`endif
        .req       (req),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .ready     (ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference recurrence: n left shifts with feedback bit19 ^ bit16.
    function automatic logic [19:0] adv(input logic [19:0] v, input int n);
        for (int k = 0; k < n; k++) v = {v[18:0], v[19] ^ v[16]};
        return v;
    endfunction

    // Waits for a grant pulse; returns the cycle stamp it was seen at.
    task automatic wait_grant(input string tag, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rnd_valid && n < 200);
        if (!rnd_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
        at = cyc;
    endtask

    // Counts falling edges until ready is seen.
    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [N_REQ-1:0] rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N_REQ-1:0] skp_exp [3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [19:0]      words   [5];
    logic [19:0]      m;
    int               n, at, prev;
    logic             changed;

    initial begin
        rst = 1'b1;
        req = '0;
`ifdef RNG_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_in   = '0;
`endif
        #2 rst = 1'b0;
        #1;
        check("rst_gnt",   32'(gnt), 32'd0);
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_data",  32'(rnd_data), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);

        // ---- 1: first word after reset ----
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_ready("first_ready", n);
        check("first_ready_lat", 32'(n), 32'(STEPS));
        req = 4'b0001;
        @(negedge clk);
        check("first_gnt",   32'(gnt), 32'b0001);
        check("first_valid", 32'(rnd_valid), 32'd1);
        check("first_data",  32'(rnd_data), 32'h00009);
        check("first_model", 32'(rnd_data), 32'(adv(SEED, STEPS)));
        check("first_busy",  32'(ready), 32'd0);
        req = '0;
        @(negedge clk);
        check("first_gnt_clr",   32'(gnt), 32'd0);
        check("first_valid_clr", 32'(rnd_valid), 32'd0);
        check("first_data_hold", 32'(rnd_data), 32'h00009);

        // ---- 2: rotation under contention, from a fresh reset ----
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        prev = cyc;
        m = SEED;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rot", at);
            m = adv(m, STEPS);
            check($sformatf("rot%0d_gap", k),  32'(at - prev), 32'(SPACE));
            check($sformatf("rot%0d_gnt", k),  32'(gnt), 32'(rot_exp[k]));
            check($sformatf("rot%0d_data", k), 32'(rnd_data), 32'(m));
            words[k] = rnd_data;
            prev = at;
            @(negedge clk);
            check($sformatf("rot%0d_pulse", k), 32'({gnt, rnd_valid}), 32'd0);
        end
        for (int a = 0; a < 5; a++)
            for (int b = a + 1; b < 5; b++)
                check($sformatf("rot_distinct_%0d_%0d", a, b),
                      32'(words[a] == words[b]), 32'd0);

        // ---- 3: skipping non-requesters ----
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            wait_grant("skip", at);
            m = adv(m, STEPS);
            check($sformatf("skip%0d_gap", k),  32'(at - prev), 32'(SPACE));
            check($sformatf("skip%0d_gnt", k),  32'(gnt), 32'(skp_exp[k]));
            check($sformatf("skip%0d_req0", k), 32'(gnt[0]), 32'd0);
            check($sformatf("skip%0d_data", k), 32'(rnd_data), 32'(m));
            prev = at;
            @(negedge clk);
        end

        // ---- 4: idle in READY keeps the staged word ----
        req = '0;
        wait_ready("idle_ready", n);
        changed = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rnd_data !== m || ready !== 1'b1 || rnd_valid !== 1'b0) changed = 1'b1;
        end
        check("idle_hold", 32'(changed), 32'd0);
        req = 4'b0100;
        @(negedge clk);
        m = adv(m, STEPS);
        check("idle_gnt",  32'(gnt), 32'b0100);
        check("idle_data", 32'(rnd_data), 32'(m));
        req = '0;

        // ---- 5: reset on the 10th REFILL cycle after a grant ----
        for (int k = 0; k < 9; k++) @(negedge clk);
        check("mid_pre_data", 32'(rnd_data), 32'(m));
        rst = 1'b0;
        #1;
        check("mid_rst_gnt",   32'(gnt), 32'd0);
        check("mid_rst_valid", 32'(rnd_valid), 32'd0);
        check("mid_rst_data",  32'(rnd_data), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0001;
        prev = cyc;
        wait_grant("mid_after", at);
        check("mid_after_gap",  32'(at - prev), 32'(SPACE));
        check("mid_after_gnt",  32'(gnt), 32'b0001);
        check("mid_after_data", 32'(rnd_data), 32'h00009);

        // Reset landing in the grant cycle itself.
        rst = 1'b0;
        req = '0;
        #1;
        check("gnt_rst_gnt",   32'(gnt), 32'd0);
        check("gnt_rst_valid", 32'(rnd_valid), 32'd0);
        check("gnt_rst_data",  32'(rnd_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef RNG_SEED_LOAD_EN
        // ---- 6: seed load ----
        for (int k = 0; k < 7; k++) @(negedge clk);  // mid-refill, LFSR != SEED
        seed_load = 1'b1;
        seed_in   = 20'h00000;
        @(negedge clk);
        seed_load = 1'b0;
        wait_ready("load0_ready", n);
        check("load0_ready_lat", 32'(n), 32'(STEPS));
        req = 4'b0001;
        @(negedge clk);
        check("load0_gnt",  32'(gnt), 32'b0001);
        check("load0_data", 32'(rnd_data), 32'h00009);
        req = '0;
        wait_ready("load1_pre", n);
        seed_load = 1'b1;
        seed_in   = 20'h12345;
        req       = 4'b0010;
        @(negedge clk);
        seed_load = 1'b0;
        check("load1_no_gnt",   32'(gnt), 32'd0);
        check("load1_no_valid", 32'(rnd_valid), 32'd0);
        check("load1_refill",   32'(ready), 32'd0);
        wait_ready("load1_ready", n);
        check("load1_ready_lat", 32'(n), 32'(STEPS));
        @(negedge clk);
        check("load1_gnt",  32'(gnt), 32'b0010);
        check("load1_data", 32'(rnd_data), 32'(adv(20'h12345, STEPS)));
        req = '0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
